commit_trace_unit: RTL and testbench
====================================

// Module: commit_trace_unit
// PURPOSE
//  Source end of the retire/debug trace consumed by the CPU benches: sits behind the ROB commit port inside O3O_CPU.
//  Registers one retire event per cycle onto retire_valid_reg/retire_addr_reg and counts cycles and retired instructions.
//  Detects end of program: a halt instruction retires, then the store buffer drains, then done.
//  Flags abnormal termination (cycle timeout, commit stall) so benches stop on abort instead of a free-running counter.
// PARAMETERS
//  ADDR_WIDTH   32      width of commit/retire PC
//  CNT_WIDTH    32      width of cycle_count / retired_count
//  MAX_CYCLES   100000  cycle_count value at which timeout abort fires
//  STALL_LIMIT  1024    consecutive no-commit cycles in RUN that raise a stall abort
// PORTS
//  clk               in   1           clock, rising edge
//  rst               in   1           asynchronous reset, active-high
//  commit_valid      in   1           ROB commits one instruction this cycle
//  commit_addr       in   ADDR_WIDTH  PC of committing instruction
//  commit_is_halt    in   1           committing instruction is ecall/ebreak halt (qualified by commit_valid)
//  commit_flush      in   1           pipeline flush issued this cycle (mispredict recovery)
//  sb_empty          in   1           store buffer holds no pending stores
//  retire_valid_reg  out  1           registered retire strobe
//  retire_addr_reg   out  ADDR_WIDTH  registered PC of last reported retire
//  done              out  1           clean program end; sticky
//  abort             out  1           abnormal end (timeout or stall); sticky
//  abort_cause       out  2           00 none, 01 timeout, 10 stall
//  cycle_count       out  CNT_WIDTH   cycles since reset release
//  retired_count     out  CNT_WIDTH   instructions reported retired
// BEHAVIOUR
//  Reset (async, any time, incl. mid-DRAIN): state=RUN; all outputs and internal counters 0.
//  States: RUN -> DRAIN on halt commit; DRAIN -> DONE on sb_empty; RUN/DRAIN -> ABORT on timeout; RUN -> ABORT on stall.
//   DONE and ABORT are terminal until reset.
//  Report: in RUN, commit_valid -> next cycle retire_valid_reg=1, retire_addr_reg=commit_addr (1-cycle latency).
//   No commit -> retire_valid_reg=0, retire_addr_reg holds. Halt instruction itself is reported.
//   In DRAIN/DONE/ABORT commits are ignored: retire_valid_reg=0, retired_count frozen.
//  retired_count: +1 per reported retire; saturates at all-ones.
//  cycle_count: +1 each cycle in RUN/DRAIN; frozen in DONE/ABORT; saturates at all-ones.
//  Timeout: when cycle_count == MAX_CYCLES-1 and incrementing -> ABORT, abort_cause=01.
//  Stall counter: clears on reported retire or commit_flush; else +1 in RUN; reaching STALL_LIMIT -> ABORT, cause=10.
//  DRAIN: minimum one cycle even if sb_empty already 1 at halt commit; DONE entered on first DRAIN-cycle edge with sb_empty=1.
//  done = (state==DONE), registered; first high the cycle after that edge. abort = (state==ABORT), registered.
//  Priority same cycle: timeout > halt > stall. Halt with commit_flush same cycle: halt wins (instruction committed).
//  abort_cause written once on ABORT entry, never changes until reset. done and abort never both 1.
// TESTING
//  1 Commit PCs 0x0,0x4,0x8 on 3 consecutive cycles -> retire_valid_reg=1 with addr 0x0,0x4,0x8 one cycle later; retired_count=3.
//  2 Halt at 0x20 with sb_empty=0 for 5 cycles then 1 -> 0x20 reported, state DRAIN 6 cycles, done=1 next, cycle_count frozen.
//  3 Halt with sb_empty already 1 -> exactly one DRAIN cycle, done asserted 2 cycles after halt commit; later commits not reported.
//  4 MAX_CYCLES=50, no halt, steady commits -> abort=1, abort_cause=01, cycle_count=50, done=0.
//  5 STALL_LIMIT=8, no commit/flush 8 cycles -> abort cause 10; variant: flush at cycle 7 restarts count, no abort at 8.
//  6 Assert rst mid-DRAIN -> all outputs 0 immediately (async); after release, commit 0x100 reported normally.

Source files
------------

// File: rtl/commit_trace_unit.sv
// Retire/debug trace source behind the ROB commit port: registers retire events,
// counts cycles and retirements, and detects clean (halt + drain) or aborted program end.
module commit_trace_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int MAX_CYCLES  = 100000,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic [ADDR_WIDTH-1:0] commit_addr,
  input  logic                  commit_is_halt,
  input  logic                  commit_flush,
  input  logic                  sb_empty,
  output logic                  retire_valid_reg,
  output logic [ADDR_WIDTH-1:0] retire_addr_reg,
  output logic                  done,
  output logic                  abort,
  output logic [1:0]            abort_cause,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_AT = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [STALL_W-1:0]   STALL_AT   = STALL_W'(STALL_LIMIT);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_ABORT} state_t;

  state_t                state_q, state_d;
  logic                  retire_valid_q;
  logic [ADDR_WIDTH-1:0] retire_addr_q;
  logic                  done_q, abort_q;
  logic [1:0]            cause_q, cause_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic [STALL_W-1:0]    stall_q, stall_d;

  logic run, active, report, timeout, stall_hit;

  always_comb begin
    run       = (state_q == S_RUN);
    active    = run || (state_q == S_DRAIN);
    report    = run && commit_valid;
    timeout   = active && (cycle_q != '1) && (cycle_q == TIMEOUT_AT);
    cycle_d   = cycle_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    state_d   = state_q;
    cause_d   = cause_q;
    if (active && (cycle_q != '1)) cycle_d = cycle_q + CNT_WIDTH'(1);
    if (report && (retired_q != '1)) retired_d = retired_q + CNT_WIDTH'(1);
    if (run) stall_d = (report || commit_flush) ? '0 : stall_q + STALL_W'(1);
    stall_hit = run && (stall_d == STALL_AT);
    // Priority: timeout over halt over stall; a halt commit also clears the stall count.
    case (state_q)
      S_RUN: begin
        if (timeout) begin
          state_d = S_ABORT;
          cause_d = 2'b01;
        end else if (report && commit_is_halt) begin
          state_d = S_DRAIN;
        end else if (stall_hit) begin
          state_d = S_ABORT;
          cause_d = 2'b10;
        end
      end
      S_DRAIN: begin
        if (timeout) begin
          state_d = S_ABORT;
          cause_d = 2'b01;
        end else if (sb_empty) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      retire_valid_q <= 1'b0;
      retire_addr_q  <= '0;
      done_q         <= 1'b0;
      abort_q        <= 1'b0;
      cause_q        <= 2'b00;
      cycle_q        <= '0;
      retired_q      <= '0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      retire_valid_q <= report;
      if (report) retire_addr_q <= commit_addr;
      done_q         <= (state_d == S_DONE);
      abort_q        <= (state_d == S_ABORT);
      cause_q        <= cause_d;
      cycle_q        <= cycle_d;
      retired_q      <= retired_d;
      stall_q        <= stall_d;
    end
  end

  assign retire_valid_reg = retire_valid_q;
  assign retire_addr_reg  = retire_addr_q;
  assign done             = done_q;
  assign abort            = abort_q;
  assign abort_cause      = cause_q;
  assign cycle_count      = cycle_q;
  assign retired_count    = retired_q;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed and randomized bench for commit_trace_unit against a flag-based behavioural model.
module tb_commit_trace_unit;

  localparam int AW   = 32;
  localparam int CW   = 32;
  localparam int MAXC = 50;
  localparam int STL  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cv = 1'b0, ch = 1'b0, cf = 1'b0, sbe = 1'b0;
  logic [AW-1:0] ca = '0;
  logic          retire_valid_reg, done, abort;
  logic [AW-1:0] retire_addr_reg;
  logic [1:0]    abort_cause;
  logic [CW-1:0] cycle_count, retired_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: program phase as flags, counters as plain integers.
  bit          m_halted, m_done, m_abort, m_rv;
  int unsigned m_cause, m_cyc, m_ret, m_silent;
  logic [31:0] m_ra;

  commit_trace_unit #(
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MAX_CYCLES(MAXC), .STALL_LIMIT(STL)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_valid(cv), .commit_addr(ca), .commit_is_halt(ch),
    .commit_flush(cf), .sb_empty(sbe),
    .retire_valid_reg(retire_valid_reg), .retire_addr_reg(retire_addr_reg),
    .done(done), .abort(abort), .abort_cause(abort_cause),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("retire_valid", {31'b0, retire_valid_reg}, {31'b0, m_rv});
    chk("retire_addr", retire_addr_reg, m_ra);
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("abort", {31'b0, abort}, {31'b0, m_abort});
    chk("abort_cause", {30'b0, abort_cause}, m_cause);
    chk("cycle_count", cycle_count, m_cyc);
    chk("retired_count", retired_count, m_ret);
  endtask

  task automatic model_reset();
    m_halted = 0; m_done = 0; m_abort = 0; m_rv = 0;
    m_cause = 0; m_cyc = 0; m_ret = 0; m_silent = 0; m_ra = '0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] a, input bit h, input bit f, input bit s);
    bit running, draining, rep, tmo;
    running  = !m_halted && !m_done && !m_abort;
    draining = m_halted && !m_done && !m_abort;
    rep      = running && v;
    tmo      = (running || draining) && (m_cyc == MAXC - 1);
    m_rv = rep;
    if (rep) begin
      m_ra = a;
      m_ret++;
    end
    if (running || draining) m_cyc++;
    if (running) m_silent = (rep || f) ? 0 : m_silent + 1;
    if (tmo) begin
      m_abort = 1; m_cause = 1;
    end else if (rep && h) begin
      m_halted = 1;
    end else if (running && m_silent == STL) begin
      m_abort = 1; m_cause = 2;
    end else if (draining && s) begin
      m_done = 1;
    end
  endtask

  task automatic step(input bit v, input logic [31:0] a, input bit h, input bit f, input bit s);
    cv = v; ca = a; ch = h; cf = f; sbe = s;
    @(posedge clk);
    model_edge(v, a, h, f, s);
    #1 check_all();
  endtask

  // Reset is raised away from any clock edge to exercise the asynchronous path.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    cv = 0; ch = 0; cf = 0; sbe = 0; ca = '0;
  endtask

  initial begin
    do_reset();

    // Back-to-back commits reported with one cycle of latency
    step(1, 32'h0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0);
    step(1, 32'h8, 0, 0, 0);
    chk("t1_addr", retire_addr_reg, 32'h8);
    step(0, 32'h0, 0, 0, 0);
    chk("t1_count", retired_count, 32'd3);

    // Halt with slow store-buffer drain
    do_reset();
    step(1, 32'h20, 1, 0, 0);
    chk("t2_halt_addr", retire_addr_reg, 32'h20);
    for (int i = 0; i < 5; i++) step(1, 32'h24, 0, 0, 0);
    chk("t2_still_drain", {31'b0, done}, 32'd0);
    step(0, 32'h0, 0, 0, 1);
    chk("t2_done", {31'b0, done}, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 32'h28, 0, 0, 1);
    chk("t2_cycle_frozen", cycle_count, 32'd7);

    // Halt with store buffer already empty: one DRAIN cycle only
    do_reset();
    step(1, 32'h40, 1, 0, 1);
    chk("t3_done_early", {31'b0, done}, 32'd0);
    step(1, 32'h44, 0, 0, 1);
    chk("t3_done", {31'b0, done}, 32'd1);
    step(1, 32'h48, 0, 0, 1);
    chk("t3_no_report", {31'b0, retire_valid_reg}, 32'd0);
    chk("t3_ret_frozen", retired_count, 32'd1);

    // Cycle timeout under steady commits
    do_reset();
    for (int i = 0; i < 60; i++) step(1, 32'(i * 4), 0, 0, 0);
    chk("t4_cause", {30'b0, abort_cause}, 32'd1);
    chk("t4_cycles", cycle_count, 32'd50);
    chk("t4_done", {31'b0, done}, 32'd0);

    // Commit stall abort, then flush restarting the stall window
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 32'h0, 0, 0, 0);
    chk("t5_cause", {30'b0, abort_cause}, 32'd2);
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 32'h0, 0, 0, 0);
    chk("t5_flush_no_abort", {31'b0, abort}, 32'd0);
    step(1, 32'h60, 0, 0, 0);

    // Reset in the middle of DRAIN
    do_reset();
    step(1, 32'h10, 1, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    do_reset();
    step(1, 32'h100, 0, 0, 0);
    chk("t6_valid", {31'b0, retire_valid_reg}, 32'd1);
    chk("t6_addr", retire_addr_reg, 32'h100);

    // Randomized episodes
    for (int ep = 0; ep < 8; ep++) begin
      int len;
      do_reset();
      len = $urandom_range(20, 70);
      for (int i = 0; i < len; i++) begin
        bit v, h, f, s;
        logic [31:0] a;
        v = ($urandom % 10) < 7;
        h = v && (($urandom % 25) == 0);
        f = ($urandom % 10) == 0;
        s = $urandom % 2;
        a = $urandom & 32'hFFFF_FFFC;
        step(v, a, h, f, s);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
